// File: rtl/clk_trig_pkg.sv
// Shared definitions for the clock+trigger link receiver: FSM state encoding and mode codes.
package clk_trig_pkg;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_TRACK   = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam logic MODE_DUTY = 1'b0;
  localparam logic MODE_MISS = 1'b1;

endpackage

// File: rtl/cnt_in_sync.sv
// Two-flop synchronizer for the encoded line plus a registered rising-edge detector.
// level_o and rise_o change together, three fastclk edges after the input rises.
module cnt_in_sync (
  input  logic fastclk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [2:0] sync_q;
  logic       rise_q;

  always_ff @(posedge fastclk or posedge reset) begin
    if (reset) begin
      sync_q <= 3'b000;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
      rise_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign level_o = sync_q[2];
  assign rise_o  = rise_q;

endmodule

// File: rtl/clk_trig_decoder.sv
// Receive side of the clock+trigger link: measures each encoded period, decodes the trigger
// bit (duty-cycle or missing-pulse), tracks lock and regenerates a 50% duty clock.
module clk_trig_decoder
  import clk_trig_pkg::*;
#(
  parameter int OVERSAMPLE = 8,
  parameter int TOL        = 1,
  parameter int CNT_W      = 6,
  parameter int LOCK_COUNT = 16
) (
  input  logic fastclk,
  input  logic reset,
  input  logic mode,
  input  logic enc_in,
  output logic clk_rec,
  output logic sym_stb,
  output logic trig_out,
  output logic locked,
  output logic err_stb
);

  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);
  localparam int HALF_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  P_MIN     = CNT_W'(OVERSAMPLE - TOL);
  localparam logic [CNT_W-1:0]  P_MAX     = CNT_W'(OVERSAMPLE + TOL);
  localparam logic [CNT_W-1:0]  P_NOM     = CNT_W'(OVERSAMPLE);
  localparam logic [CNT_W-1:0]  P_MISS    = CNT_W'(OVERSAMPLE + OVERSAMPLE / 2);
  localparam logic [CNT_W:0]    EXT_ONE   = (CNT_W + 1)'(1);
  localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(OVERSAMPLE / 2 - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_COUNT - 1);

  logic level, rise;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic              mode_q;
  logic              clk_rec_q, clk_rec_d;
  logic              sym_stb_q, sym_stb_d;
  logic              err_stb_q, err_stb_d;
  logic              trig_q, trig_d;
  logic              locked_q, locked_d;

  logic              edge_evt, sym_evt, sym_val, err_evt;
  logic [CNT_W:0]    two_h, p_ext;
  logic              p_valid, ambiguous, duty_trig, mode_chg, timeout, saturated;

  cnt_in_sync u_sync (
    .fastclk (fastclk),
    .reset   (reset),
    .d_i     (enc_in),
    .level_o (level),
    .rise_o  (rise)
  );

  assign two_h     = {high_q, 1'b0};
  assign p_ext     = {1'b0, period_q};
  assign p_valid   = (period_q >= P_MIN) && (period_q <= P_MAX);
  assign ambiguous = (two_h <= p_ext + EXT_ONE) && (p_ext <= two_h + EXT_ONE);
  assign duty_trig = two_h < p_ext;
  assign mode_chg  = mode != mode_q;
  assign timeout   = (mode_q == MODE_MISS) && (period_q == P_MISS);
  assign saturated = period_q == CNT_MAX;

  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    trig_d    = trig_q;
    sym_stb_d = 1'b0;
    err_stb_d = 1'b0;
    edge_evt  = 1'b0;
    sym_evt   = 1'b0;
    sym_val   = 1'b0;
    err_evt   = 1'b0;

    if (rise) begin
      period_d = CNT_ONE;
      high_d   = CNT_ONE;
    end else begin
      period_d = saturated ? period_q : period_q + CNT_ONE;
      high_d   = (high_q == CNT_MAX) ? high_q : high_q + {{(CNT_W-1){1'b0}}, level};
    end

    if (mode_chg) begin
      state_d = ST_ACQUIRE;
      lock_d  = '0;
    end else if (state_q == ST_ACQUIRE) begin
      if (rise) begin
        state_d  = ST_TRACK;
        lock_d   = '0;
        edge_evt = 1'b1;
      end
    end else if (rise) begin
      edge_evt = 1'b1;
      if (!p_valid || ((mode_q == MODE_DUTY) && ambiguous)) begin
        err_evt = 1'b1;
      end else begin
        sym_evt = 1'b1;
        sym_val = (mode_q == MODE_DUTY) ? duty_trig : 1'b0;
      end
    end else if (timeout) begin
      // Synthetic edge: pull the count back one period so a later rise still measures nominal.
      edge_evt = 1'b1;
      sym_evt  = 1'b1;
      sym_val  = 1'b1;
      period_d = period_q + CNT_ONE - P_NOM;
    end else if (saturated) begin
      state_d = ST_ACQUIRE;
      lock_d  = '0;
    end

    if (err_evt) begin
      err_stb_d = 1'b1;
      state_d   = ST_TRACK;
      lock_d    = '0;
    end

    if (sym_evt) begin
      if (state_q == ST_LOCKED) begin
        sym_stb_d = 1'b1;
        trig_d    = sym_val;
      end else begin
        lock_d = lock_q + LOCK_W'(1);
        if (lock_q == LOCK_LAST) begin
          state_d = ST_LOCKED;
        end
      end
    end

    clk_rec_d = clk_rec_q;
    half_d    = half_q;
    if (state_d == ST_ACQUIRE) begin
      clk_rec_d = 1'b0;
      half_d    = '0;
    end else if (edge_evt) begin
      clk_rec_d = 1'b1;
      half_d    = HALF_LOAD;
    end else if (clk_rec_q) begin
      if (half_q == '0) begin
        clk_rec_d = 1'b0;
      end else begin
        half_d = half_q - HALF_W'(1);
      end
    end

    locked_d = state_d == ST_LOCKED;
  end

  always_ff @(posedge fastclk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ACQUIRE;
      period_q  <= '0;
      high_q    <= '0;
      lock_q    <= '0;
      half_q    <= '0;
      mode_q    <= 1'b0;
      clk_rec_q <= 1'b0;
      sym_stb_q <= 1'b0;
      err_stb_q <= 1'b0;
      trig_q    <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      high_q    <= high_d;
      lock_q    <= lock_d;
      half_q    <= half_d;
      mode_q    <= mode;
      clk_rec_q <= clk_rec_d;
      sym_stb_q <= sym_stb_d;
      err_stb_q <= err_stb_d;
      trig_q    <= trig_d;
      locked_q  <= locked_d;
    end
  end

  assign clk_rec  = clk_rec_q;
  assign sym_stb  = sym_stb_q;
  assign trig_out = trig_q;
  assign locked   = locked_q;
  assign err_stb  = err_stb_q;

endmodule

// File: tb/tb_clk_trig_decoder.sv
// Bench for clk_trig_decoder: segment-level stimulus, period-level reference model of the
// decoding rules, event-sequence comparison plus per-period lock/trigger-hold checks.
module tb_clk_trig_decoder;

  localparam int OS         = 8;
  localparam int LOCK_COUNT = 16;
  localparam int SAT        = 63;

  logic fastclk = 1'b0;
  logic reset   = 1'b1;
  logic mode    = 1'b0;
  logic enc_in  = 1'b0;
  logic clk_rec, sym_stb, trig_out, locked, err_stb;

  always #5 fastclk = ~fastclk;

  clk_trig_decoder #(
    .OVERSAMPLE (OS),
    .TOL        (1),
    .CNT_W      (6),
    .LOCK_COUNT (LOCK_COUNT)
  ) dut (
    .fastclk  (fastclk),
    .reset    (reset),
    .mode     (mode),
    .enc_in   (enc_in),
    .clk_rec  (clk_rec),
    .sym_stb  (sym_stb),
    .trig_out (trig_out),
    .locked   (locked),
    .err_stb  (err_stb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Event codes: 0/1 = symbol with that trigger bit, 2 = error, 3 = both strobes at once.
  int exp_q[$];
  int dut_q[$];

  int m_state;   // 0 acquire, 1 track, 2 locked
  int m_lock;
  int m_trig;
  bit m_mode;
  bit prev_v;
  int t_now       = 0;
  int last_rise_t = 0;
  int high_acc;
  int clk_hi_cnt  = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_state  = 0;
    m_lock   = 0;
    m_trig   = 0;
    high_acc = 0;
    prev_v   = 1'b0;
  endfunction

  function automatic void m_symbol(input int trig);
    if (m_state == 2) begin
      exp_q.push_back(trig);
      m_trig = trig;
    end else begin
      m_lock++;
      if (m_lock == LOCK_COUNT) m_state = 2;
    end
  endfunction

  function automatic void m_error();
    exp_q.push_back(2);
    m_state = 1;
    m_lock  = 0;
  endfunction

  // d = cycles since previous rise, h = high cycles in that interval.
  function automatic void m_rise(input int d, input int h);
    int k, p, diff;
    if (m_state == 0 || (!m_mode && d > SAT)) begin
      m_state = 1;
      m_lock  = 0;
      return;
    end
    if (m_mode) begin
      k = 0;
      while (OS * (k + 1) + OS / 2 < d) begin
        m_symbol(1);
        k++;
      end
      p = d - OS * k;
      if (p >= OS - 1 && p <= OS + 1) m_symbol(0);
      else m_error();
    end else begin
      p    = d;
      diff = 2 * h - p;
      if (diff < 0) diff = -diff;
      if (p < OS - 1 || p > OS + 1 || diff <= 1) m_error();
      else m_symbol((2 * h < p) ? 1 : 0);
    end
  endfunction

  task automatic drive_bit(input bit v);
    @(posedge fastclk);
    #1;
    enc_in = v;
    t_now++;
    if (v && !prev_v) begin
      m_rise(t_now - last_rise_t, high_acc);
      last_rise_t = t_now;
      high_acc    = 0;
    end
    if (v) high_acc++;
    prev_v = v;
    @(negedge fastclk);
    if (sym_stb && err_stb) dut_q.push_back(3);
    else if (sym_stb)       dut_q.push_back(int'(trig_out));
    else if (err_stb)       dut_q.push_back(2);
    clk_hi_cnt += int'(clk_rec);
  endtask

  task automatic send_seg(input int p, input int h);
    bit rs;
    rs = (h > 0) && !prev_v;
    for (int i = 0; i < p; i++) drive_bit(i < h);
    if (rs && p >= 5 && p <= 16) begin
      check_val("locked", int'(locked), (m_state == 2) ? 1 : 0);
      check_val("trig_hold", int'(trig_out), m_trig);
    end
  endtask

  task automatic set_mode(input bit m);
    mode    = m;
    m_mode  = m;
    m_state = 0;
    m_lock  = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_clk_rec"}, int'(clk_rec), 0);
    check_val({tag, "_sym_stb"}, int'(sym_stb), 0);
    check_val({tag, "_trig_out"}, int'(trig_out), 0);
    check_val({tag, "_locked"}, int'(locked), 0);
    check_val({tag, "_err_stb"}, int'(err_stb), 0);
  endtask

  task automatic rand_duty_seg();
    int r, p;
    r = $urandom_range(0, 19);
    p = $urandom_range(OS - 1, OS + 1);
    if (r == 0)      send_seg(OS + 3, OS);
    else if (r == 1) send_seg(OS, OS / 2);
    else if (r < 11) send_seg(p, p - 2);
    else             send_seg(p, 2);
  endtask

  task automatic rand_miss_seg();
    int r, p, n;
    r = $urandom_range(0, 9);
    p = $urandom_range(OS - 1, OS + 1);
    if (r == 0) begin
      send_seg(OS + 3, OS / 2);
    end else if (r < 5) begin
      send_seg(p, p / 2);
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) send_seg(OS, 0);
    end else begin
      send_seg(p, p / 2);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_cmp;
    m_reset();
    m_mode = 1'b0;
    repeat (3) @(posedge fastclk);
    #1;
    check_outputs_zero("in_reset");
    reset = 1'b0;

    // Nominal duty-cycle stream: lock after the 16th symbol, recovered clock 50% duty.
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) clk_hi_cnt = 0;
      send_seg(OS, 6);
      if (i == 18) check_val("clk_rec_duty", clk_hi_cnt, 16 * OS / 2);
    end

    // Single trigger symbol in a locked stream.
    send_seg(OS, 2);
    send_seg(OS, 6);
    send_seg(OS, 6);

    for (int i = 0; i < 40; i++) rand_duty_seg();
    for (int i = 0; i < 20; i++) send_seg(OS, 6);

    // Missing-pulse decoding.
    set_mode(1'b1);
    for (int i = 0; i < 20; i++) send_seg(OS, OS / 2);
    send_seg(OS, OS / 2);
    for (int i = 0; i < 3; i++) send_seg(OS, 0);
    send_seg(OS, OS / 2);
    send_seg(OS, OS / 2);
    for (int i = 0; i < 40; i++) rand_miss_seg();
    send_seg(OS, OS / 2);
    set_mode(1'b0);

    // Out-of-window period, then relock.
    for (int i = 0; i < 20; i++) send_seg(OS, 6);
    send_seg(OS + 3, OS);
    for (int i = 0; i < 20; i++) send_seg(OS, 6);

    // Ambiguous duty, then stuck-high line drops to acquire.
    send_seg(OS, 6);
    send_seg(OS, OS / 2);
    repeat (70) drive_bit(1'b1);
    check_val("stuck_locked", int'(locked), 0);
    check_val("stuck_clk_rec", int'(clk_rec), 0);
    repeat (4) drive_bit(1'b0);
    for (int i = 0; i < 20; i++) send_seg(OS, 6);

    // Reset mid-period while locked.
    check_val("pre_reset_locked", int'(locked), (m_state == 2) ? 1 : 0);
    repeat (6) drive_bit(1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    enc_in = 1'b0;
    repeat (2) @(posedge fastclk);
    #1;
    reset = 1'b0;
    m_reset();
    for (int i = 0; i < 20; i++) send_seg(OS, 6);

    // Mode toggle while locked.
    check_val("pre_toggle_locked", int'(locked), (m_state == 2) ? 1 : 0);
    set_mode(1'b1);
    drive_bit(1'b0);
    check_val("toggle_locked", int'(locked), (m_state == 2) ? 1 : 0);
    repeat (6) drive_bit(1'b0);

    check_val("evt_count", dut_q.size(), exp_q.size());
    n_cmp = (dut_q.size() < exp_q.size()) ? dut_q.size() : exp_q.size();
    for (int i = 0; i < n_cmp; i++) check_val($sformatf("evt%0d", i), dut_q[i], exp_q[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
